// File: rtl/sap_pkg.sv
// Shared definitions for the SAP program-counter datapath.
// Holds the default address and bus widths, the program-counter operation
// enum and the priority decode that turns raw control lines into one op.
package sap_pkg;

   localparam int SAP_ADDR_WIDTH = 4;
   localparam int SAP_BUS_WIDTH  = 8;

   typedef enum logic [2:0] {
      PC_HOLD,
      PC_INC,
      PC_LOAD,
      PC_CALL,
      PC_RET
   } pc_op_e;

   // Only one operation is ever executed per edge; ret wins over call,
   // call over load, load over increment.
   function automatic pc_op_e decode_op(input logic ret,
                                        input logic call,
                                        input logic load,
                                        input logic increment);
      pc_op_e op;
      if (ret)
         op = PC_RET;
      else if (call)
         op = PC_CALL;
      else if (load)
         op = PC_LOAD;
      else if (increment)
         op = PC_INC;
      else
         op = PC_HOLD;
      return op;
   endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Return-address LIFO for the program counter.
// Ports:
//   clock  - state updates on the falling edge
//   reset  - synchronous active-high, clears the occupancy count only
//   push   - write din as the new top entry (caller guarantees not full)
//   pop    - discard the top entry (caller guarantees not empty)
//   din    - return address to push
//   dout   - current top entry (undefined content when empty)
//   empty  - no entries held
//   full   - DEPTH entries held
module pc_return_stack #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   if (DEPTH < 1) begin : g_depth_check
      $error("pc_return_stack: DEPTH must be at least 1");
   end

   logic [WIDTH-1:0] mem [DEPTH];
   logic [CNT_W-1:0] count;
   logic [IDX_W-1:0] top_idx;
   logic [IDX_W-1:0] wr_idx;

   // count points one past the top; when count is 0 top_idx is don't-care.
   assign top_idx = IDX_W'(count - CNT_W'(1));
   assign wr_idx  = IDX_W'(count);

   assign dout  = mem[top_idx];
   assign empty = (count == '0);
   assign full  = (count == CNT_W'(DEPTH));

   always_ff @(negedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (push) begin
         count <= count + CNT_W'(1);
      end else if (pop) begin
         count <= count - CNT_W'(1);
      end
   end

   // Entries are left intact on reset; only the count defines validity.
   always_ff @(negedge clock) begin
      if (!reset && push) begin
         mem[wr_idx] <= din;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with call/return stack for the SAP datapath.
// Ports:
//   clock          - all state updates on the falling edge
//   reset          - synchronous active-high, overrides every command
//   output_to_bus  - Ep, register the current address onto bus_out
//   increment      - Cp, advance the address
//   load           - Lp, jump to bus_in[ADDR_WIDTH-1:0]
//   call           - push address+1, jump to bus_in[ADDR_WIDTH-1:0]
//   ret            - pop the return address into the counter
//   bus_in         - W-bus value used by load and call
//   bus_out        - registered zero-extended address (0 when not driving)
//   bus_oe         - registered drive enable for the top-level tri-state
//   address        - current program counter
//   stack_empty    - no return addresses held
//   stack_full     - STACK_DEPTH return addresses held
//   wrapped        - one-cycle pulse after an increment rolls over to 0
//   stack_error    - sticky overflow/underflow flag, cleared by reset
module pc_sequencer
   import sap_pkg::*;
#(
   parameter int ADDR_WIDTH  = SAP_ADDR_WIDTH,
   parameter int BUS_WIDTH   = SAP_BUS_WIDTH,
   parameter int STACK_DEPTH = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  output_to_bus,
   input  logic                  increment,
   input  logic                  load,
   input  logic                  call,
   input  logic                  ret,
   input  logic [BUS_WIDTH-1:0]  bus_in,
   output logic [BUS_WIDTH-1:0]  bus_out,
   output logic                  bus_oe,
   output logic [ADDR_WIDTH-1:0] address,
   output logic                  stack_empty,
   output logic                  stack_full,
   output logic                  wrapped,
   output logic                  stack_error
);

   if (BUS_WIDTH < ADDR_WIDTH) begin : g_width_check
      $error("pc_sequencer: BUS_WIDTH must be >= ADDR_WIDTH");
   end

   pc_op_e                op;
   logic [ADDR_WIDTH-1:0] address_nxt;
   logic [ADDR_WIDTH-1:0] bus_addr;
   logic [ADDR_WIDTH-1:0] ret_addr;
   logic [ADDR_WIDTH-1:0] stack_top;
   logic                  wrapped_nxt;
   logic                  err_set;
   logic                  push;
   logic                  pop;
   logic                  bus_unused;

   // Bits above the address width carry no meaning for the counter.
   assign bus_addr   = bus_in[ADDR_WIDTH-1:0];
   assign bus_unused = &{1'b0, bus_in};

   assign op       = decode_op(ret, call, load, increment);
   assign ret_addr = address + ADDR_WIDTH'(1);

   always_comb begin
      address_nxt = address;
      wrapped_nxt = 1'b0;
      err_set     = 1'b0;
      push        = 1'b0;
      pop         = 1'b0;
      unique case (op)
         PC_INC: begin
            address_nxt = address + ADDR_WIDTH'(1);
            wrapped_nxt = &address;
         end
         PC_LOAD: begin
            address_nxt = bus_addr;
         end
         PC_CALL: begin
            if (stack_full) begin
               err_set = 1'b1;
            end else begin
               push        = 1'b1;
               address_nxt = bus_addr;
            end
         end
         PC_RET: begin
            if (stack_empty) begin
               err_set = 1'b1;
            end else begin
               pop         = 1'b1;
               address_nxt = stack_top;
            end
         end
         default: ;
      endcase
   end

   always_ff @(negedge clock) begin
      if (reset) begin
         address     <= '0;
         bus_out     <= '0;
         bus_oe      <= 1'b0;
         wrapped     <= 1'b0;
         stack_error <= 1'b0;
      end else begin
         address     <= address_nxt;
         // Bus shows the address as it was before this edge's update.
         bus_out     <= output_to_bus ? BUS_WIDTH'(address) : '0;
         bus_oe      <= output_to_bus;
         wrapped     <= wrapped_nxt;
         stack_error <= stack_error | err_set;
      end
   end

   pc_return_stack #(
      .DEPTH (STACK_DEPTH),
      .WIDTH (ADDR_WIDTH)
   ) u_stack (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (ret_addr),
      .dout  (stack_top),
      .empty (stack_empty),
      .full  (stack_full)
   );

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, program address width in bits.
REQ-002 Parameter BUS_WIDTH, default 8, W-bus width in bits; SHALL be >= ADDR_WIDTH (elaboration error otherwise).
REQ-003 Parameter STACK_DEPTH, default 4, number of return-address entries; SHALL be >= 1.
REQ-004 clock  input  1  single clock; all state SHALL update on the falling edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 output_to_bus  input  1  Ep: drive current address onto the W-bus.
REQ-007 increment  input  1  Cp: advance address by one.
REQ-008 load  input  1  Lp: jump to bus_in[ADDR_WIDTH-1:0].
REQ-009 call  input  1  push return address, then jump to bus_in[ADDR_WIDTH-1:0].
REQ-010 ret  input  1  pop return address into the counter.
REQ-011 bus_in  input  BUS_WIDTH  W-bus value sampled for load/call.
REQ-012 bus_out  output  BUS_WIDTH  registered, zero-extended address.
REQ-013 bus_oe  output  1  registered bus drive enable; the top level does the tri-state.
REQ-014 address  output  ADDR_WIDTH  current program counter.
REQ-015 stack_empty / stack_full  output  1 each  stack occupancy flags.
REQ-016 wrapped  output  1  one-cycle pulse on increment roll-over.
REQ-017 stack_error  output  1  sticky flag for overflow or underflow.

Function
REQ-018 Command priority per edge SHALL be ret > call > load > increment > hold; lower-priority commands asserted in the same cycle are ignored.
REQ-019 increment: address <= address+1 modulo 2^ADDR_WIDTH.
REQ-020 Increment from all-ones SHALL set address to 0 and assert wrapped for exactly one cycle; wrapped is 0 otherwise.
REQ-021 load: address <= bus_in[ADDR_WIDTH-1:0]; upper bus_in bits are ignored.
REQ-022 call when not full: push (address+1) modulo 2^ADDR_WIDTH, and address <= bus_in[ADDR_WIDTH-1:0], both on the same edge.
REQ-023 call when full: no push, address unchanged, stack_error set.
REQ-024 ret when not empty: address <= top entry, and the stack pointer decrements.
REQ-025 ret when empty: address unchanged, stack_error set.
REQ-026 stack_error SHALL stay set until reset.
REQ-027 bus_oe <= output_to_bus each edge.
REQ-028 bus_out <= zero-extended pre-update address when output_to_bus=1, else 0.
REQ-029 Bus output latency is one edge: the bus shows the address that was current when Ep was sampled, not the post-increment value.
REQ-030 stack_empty = (count==0) and stack_full = (count==STACK_DEPTH), both combinational from the registered count.
REQ-031 The count SHALL never exceed STACK_DEPTH or go below 0.

Reset
REQ-032 On a falling edge with reset=1, the following SHALL be cleared:
  - address=0, bus_out=0, bus_oe=0
  - count=0, so stack_empty=1 and stack_full=0
  - wrapped=0, stack_error=0
REQ-033 Reset SHALL override all commands in the same cycle.
REQ-034 Reset mid-sequence discards stacked entries; stack contents need not be cleared, only the count.

Structure
REQ-035 Shared package sap_pkg SHALL hold:
  - SAP_ADDR_WIDTH=4 and SAP_BUS_WIDTH=8 defaults
  - enum pc_op_e {PC_HOLD, PC_INC, PC_LOAD, PC_CALL, PC_RET}, produced by the priority decode
REQ-036 Sub-module pc_return_stack(DEPTH, WIDTH) SHALL implement the LIFO.
  - Ports: push, pop, din, dout=top entry, empty, full.
  - pc_sequencer SHALL gate push/pop so the LIFO never sees an illegal request.

Verification (ADDR_WIDTH=4, BUS_WIDTH=8, STACK_DEPTH=2)
REQ-037 Reset then 16 increments: address steps 0..15 then 0; wrapped is high only in the cycle after address 15->0.
REQ-038 address=5, output_to_bus=1 with increment=1 for one edge: bus_out=8'h05, bus_oe=1, address=6.
REQ-039 Call/return sequence:
  - address=3, call with bus_in=8'hFA: address=0xA, top=4
  - call with bus_in=8'h01 at 0xA: address=1, top=0xB, stack_full=1
  - ret: address=0xB
  - ret: address=4, stack_empty=1
REQ-040 Overflow and underflow:
  - Stack full, call with bus_in=8'h07: address unchanged, stack_error=1.
  - Reset, then ret: address=0, stack_error=1.
REQ-041 Simultaneous commands:
  - ret+call+load+increment with 1 entry (value 9) stacked: address=9, stack_empty=1.
  - load+increment with bus_in=8'h0C: address=0xC.
REQ-042 Reset while count=2 and stack_error=1: next cycle address=0, stack_empty=1, stack_error=0, bus_oe=0.
